// File: rtl/spi_pkg.sv
// Shared SPI definitions: arbiter state encoding, length-width helper and default driver width.
package spi_pkg;

   localparam int SPI_MAXLEN_DFLT = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } spi_arb_state_t;

   // Length fields must hold the value SPI_MAXLEN itself, hence the extra bit.
   function automatic int len_w(input int maxlen);
      return $clog2(maxlen) + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last+1 with wraparound.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   always_comb begin
      logic [IDX_W-1:0] pos;
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      pos = '0;
      for (int off = 1; off <= N; off++) begin
         pos = IDX_W'((int'(last) + off) % N);
         if (!vld && req[pos]) begin
            vld      = 1'b1;
            idx      = pos;
            gnt[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one spi_drv master between N_REQ requesters, with
// start/ready handshake, completion pulse and per-requester slave-select demux.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int SPI_MAXLEN = SPI_MAXLEN_DFLT,
   parameter int LEN_W      = len_w(SPI_MAXLEN)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [N_REQ-1:0]                 req,
   input  logic [N_REQ-1:0][LEN_W-1:0]      req_n_clks,
   input  logic [N_REQ-1:0][SPI_MAXLEN-1:0] req_tx_data,
   output logic [N_REQ-1:0]                 gnt,
   output logic [N_REQ-1:0]                 done,
   output logic                             err,
   output logic [SPI_MAXLEN-1:0]            rx_data,
   output logic                             start_cmd,
   output logic [LEN_W-1:0]                 n_clks,
   output logic [SPI_MAXLEN-1:0]            tx_data,
   input  logic                             spi_drv_rdy,
   input  logic [SPI_MAXLEN-1:0]            rx_miso,
   input  logic                             drv_ss_n,
   output logic [N_REQ-1:0]                 ss_n
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   spi_arb_state_t   state, state_nxt;
   logic [IDX_W-1:0] last, owner;
   logic [N_REQ-1:0] win_gnt;
   logic [IDX_W-1:0] win_idx;
   logic             win_vld;
   logic [LEN_W-1:0] win_len;
   logic             arb_go, len_ok, in_xfer;

   rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req  (req),
      .last (last),
      .gnt  (win_gnt),
      .idx  (win_idx),
      .vld  (win_vld)
   );

   assign win_len = req_n_clks[win_idx];
   assign len_ok  = (win_len != '0) && (win_len <= LEN_W'(SPI_MAXLEN));
   assign arb_go  = win_vld && spi_drv_rdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (arb_go) state_nxt = len_ok ? ST_START : ST_DONE;
         ST_START: if (!spi_drv_rdy) state_nxt = ST_BUSY;
         ST_BUSY:  if (spi_drv_rdy) state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_xfer = (state == ST_START) || (state == ST_BUSY);
      ss_n    = '1;
      if (in_xfer) ss_n[owner] = drv_ss_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last      <= IDX_W'(N_REQ - 1);
         owner     <= '0;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         start_cmd <= 1'b0;
         n_clks    <= '0;
         tx_data   <= '0;
         rx_data   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_go) begin
                  last <= win_idx;
                  if (len_ok) begin
                     owner     <= win_idx;
                     gnt       <= win_gnt;
                     start_cmd <= 1'b1;
                     n_clks    <= win_len;
                     tx_data   <= req_tx_data[win_idx];
                  end else begin
                     // Rejected length: report straight away, driver untouched.
                     done <= win_gnt;
                     err  <= 1'b1;
                  end
               end
            end
            ST_START: if (!spi_drv_rdy) start_cmd <= 1'b0;
            ST_BUSY: begin
               if (spi_drv_rdy) begin
                  rx_data <= rx_miso;
                  done    <= gnt;
                  err     <= 1'b0;
               end
            end
            default: begin
               done <= '0;
               err  <= 1'b0;
               gnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural loopback SPI driver model.
module tb_spi_arbiter;

   localparam int N_REQ      = 4;
   localparam int SPI_MAXLEN = 32;
   localparam int LEN_W      = 6;

   logic                             clk = 1'b0;
   logic                             reset_n;
   logic [N_REQ-1:0]                 req;
   logic [N_REQ-1:0][LEN_W-1:0]      req_n_clks;
   logic [N_REQ-1:0][SPI_MAXLEN-1:0] req_tx_data;
   logic [N_REQ-1:0]                 gnt, done, ss_n;
   logic                             err, start_cmd, spi_drv_rdy;
   logic [SPI_MAXLEN-1:0]            rx_data, tx_data;
   logic [LEN_W-1:0]                 n_clks;

   logic                  drv_rdy = 1'b1;
   logic                  drv_ss_n = 1'b1;
   logic                  hold_off = 1'b0;
   logic [SPI_MAXLEN-1:0] rx_miso = '0;
   logic                  busy = 1'b0;
   int                    cnt = 0;
   logic [SPI_MAXLEN-1:0] lat_tx = '0;
   int                    lat_n = 0;

   int         checks = 0;
   int         errors = 0;
   int         multi_gnt = 0;
   logic [3:0] ss_low;

   assign spi_drv_rdy = drv_rdy & ~hold_off;

   spi_arbiter #(.N_REQ(N_REQ), .SPI_MAXLEN(SPI_MAXLEN), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .req_n_clks  (req_n_clks),
      .req_tx_data (req_tx_data),
      .gnt         (gnt),
      .done        (done),
      .err         (err),
      .rx_data     (rx_data),
      .start_cmd   (start_cmd),
      .n_clks      (n_clks),
      .tx_data     (tx_data),
      .spi_drv_rdy (spi_drv_rdy),
      .rx_miso     (rx_miso),
      .drv_ss_n    (drv_ss_n),
      .ss_n        (ss_n)
   );

   always #5 clk = ~clk;

   // Driver model: accepts start while ready, holds SS low n_clks cycles, loops MOSI back to MISO.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         busy = 1'b0; drv_rdy = 1'b1; drv_ss_n = 1'b1; cnt = 0;
      end else if (!busy) begin
         if (start_cmd && spi_drv_rdy) begin
            busy = 1'b1; drv_rdy = 1'b0; drv_ss_n = 1'b0;
            cnt = int'(n_clks); lat_tx = tx_data; lat_n = int'(n_clks);
         end
      end else if (cnt > 0) begin
         cnt--;
      end else begin
         busy = 1'b0; drv_rdy = 1'b1; drv_ss_n = 1'b1;
         rx_miso = (lat_n >= 32) ? lat_tx : (lat_tx & ((32'd1 << lat_n) - 32'd1));
      end
   end

   initial forever begin
      @(negedge clk);
      if ($countones(gnt) > 1) multi_gnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_gnt(input string tag, input logic [3:0] exp);
      int i = 0;
      do begin
         tick();
         i++;
      end while (gnt == '0 && i < 300);
      chk(tag, gnt, exp);
   endtask

   task automatic wait_done(input string tag, input logic [3:0] exp);
      int i = 0;
      do begin
         tick();
         ss_low |= ~ss_n;
         i++;
      end while (done == '0 && i < 300);
      chk(tag, done, exp);
   endtask

   int order[5] = '{0, 1, 2, 3, 0};
   logic [31:0] cdata[4] = '{32'h1234_563C, 32'h0000_00C3, 32'hFFFF_FF0F, 32'h0000_00F0};
   logic [31:0] cexp[4]  = '{32'h0000_003C, 32'h0000_00C3, 32'h0000_000F, 32'h0000_00F0};

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; req = '0; req_n_clks = '0; req_tx_data = '0; ss_low = '0;
      tick(); tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_start", start_cmd, 0);
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_rx", rx_data, 0);
      chk("rst_nclks", n_clks, 0);
      chk("rst_tx", tx_data, 0);

      // Driver not ready: request must wait, then win on the first ready cycle.
      hold_off = 1'b1; reset_n = 1'b1;
      req = 4'b0001; req_n_clks[0] = 6'd8; req_tx_data[0] = 32'h0000_00A5;
      repeat (4) tick();
      chk("blocked_gnt", gnt, 0);
      chk("blocked_start", start_cmd, 0);
      hold_off = 1'b0;
      tick();
      chk("single_gnt", gnt, 4'b0001);
      chk("single_start", start_cmd, 1);
      chk("single_nclks", n_clks, 8);
      chk("single_tx", tx_data, 32'hA5);
      ss_low = '0;
      wait_done("single_done", 4'b0001);
      chk("single_err", err, 0);
      chk("single_rx", rx_data, 32'hA5);
      chk("single_ss", ss_low, 4'b0001);
      req = '0;
      tick();
      chk("single_done_pulse", done, 0);
      chk("single_gnt_clr", gnt, 0);

      // Contention from a fresh pointer.
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      for (int r = 0; r < 4; r++) begin
         req_n_clks[r] = 6'd8; req_tx_data[r] = cdata[r];
      end
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_gnt($sformatf("rr_gnt%0d", t), 4'(1 << order[t]));
         chk($sformatf("rr_tx%0d", t), tx_data, cdata[order[t]]);
         wait_done($sformatf("rr_done%0d", t), 4'(1 << order[t]));
         chk($sformatf("rr_rx%0d", t), rx_data, cexp[order[t]]);
      end
      req = '0;
      tick(); tick();

      // Rejected lengths: zero and above SPI_MAXLEN.
      req_n_clks[2] = 6'd0; req = 4'b0100;
      tick();
      chk("rej0_done", done, 4'b0100);
      chk("rej0_err", err, 1);
      chk("rej0_gnt", gnt, 0);
      chk("rej0_start", start_cmd, 0);
      chk("rej0_rx", rx_data, 32'h3C);
      req = '0;
      tick();
      chk("rej0_done_clr", done, 0);
      chk("rej0_err_clr", err, 0);
      req_n_clks[2] = 6'd33; req = 4'b0100;
      tick();
      chk("rej33_done", done, 4'b0100);
      chk("rej33_err", err, 1);
      chk("rej33_start", start_cmd, 0);
      chk("rej33_rx", rx_data, 32'h3C);
      req = '0;
      tick(); tick();

      // Full-width word.
      req_n_clks[1] = 6'd32; req_tx_data[1] = 32'hDEAD_BEEF; req = 4'b0010;
      wait_gnt("full_gnt", 4'b0010);
      chk("full_nclks", n_clks, 32);
      wait_done("full_done", 4'b0010);
      chk("full_rx", rx_data, 32'hDEAD_BEEF);
      req = '0;
      tick();

      // Reset in the middle of a transfer.
      req_n_clks[1] = 6'd16; req_tx_data[1] = 32'h1234_ABCD; req = 4'b0010;
      wait_gnt("mid_gnt", 4'b0010);
      repeat (3) tick();
      chk("mid_ss", ss_n, 4'b1101);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_start", start_cmd, 0);
      chk("mid_rst_ss", ss_n, 4'hF);
      chk("mid_rst_done", done, 0);
      tick();
      reset_n = 1'b1;
      req_n_clks[3] = 6'd8; req_tx_data[3] = 32'h0000_005A; req = 4'b1000;
      wait_gnt("post_gnt", 4'b1000);
      wait_done("post_done", 4'b1000);
      chk("post_rx", rx_data, 32'h5A);
      req = '0;
      tick();

      chk("onehot_gnt", multi_gnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_drv` SPI master between `N_REQ` host requesters using round-robin arbitration. It runs the driver's start/ready handshake for the winning requester and returns the received MISO word with a one-cycle completion pulse. It also demultiplexes the driver's single slave-select onto one `ss_n` line per requester. The block sits between the host-side register clients and the `spi_drv` instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `SPI_MAXLEN`, 32: driver data width; must match the `spi_drv` instance.
- `LEN_W`, derived, `$clog2(SPI_MAXLEN)+1`: width of length fields.

Ports:
- `clk`  in  1  single clock; all logic in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester transaction request; held high until `done`.
- `req_n_clks`  in  N_REQ×LEN_W  requested SCLK count, per requester; stable while `req` is high.
- `req_tx_data`  in  N_REQ×SPI_MAXLEN  MOSI word, per requester; stable while `req` is high.
- `gnt`  out  N_REQ  one-hot owner indication.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `err`  out  1  qualifies `done`; high for rejected requests.
- `rx_data`  out  SPI_MAXLEN  last received word; valid from `done` until the next `done`.
- `start_cmd`  out  1  to `spi_drv`.
- `n_clks`  out  LEN_W  to `spi_drv`.
- `tx_data`  out  SPI_MAXLEN  to `spi_drv`.
- `spi_drv_rdy`  in  1  from `spi_drv`.
- `rx_miso`  in  SPI_MAXLEN  from `spi_drv`.
- `drv_ss_n`  in  1  `SS_N` from `spi_drv`.
- `ss_n`  out  N_REQ  per-slave selects.

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - Arbitrate only when some `req` is high and `spi_drv_rdy`=1.
  - The winner is the first requesting index found searching upward, with wraparound, from `last+1`.
  - If the winner's `req_n_clks` is in 1..SPI_MAXLEN:
    - register `n_clks` and `tx_data` from the winner;
    - set `owner`, set `gnt[owner]`, set `start_cmd`=1;
    - go to START.
  - Otherwise (0 or >SPI_MAXLEN):
    - no driver access;
    - go to DONE with `err`=1 and `gnt` low.
  - In both cases `last` <= winner.
- START: hold `start_cmd`=1 until `spi_drv_rdy` is sampled 0. Then `start_cmd` <= 0 and go to BUSY.
- BUSY: when `spi_drv_rdy` is sampled 1:
  - `rx_data` <= `rx_miso`;
  - `done[owner]` <= 1, `err` <= 0;
  - go to DONE.
- DONE: one cycle with `done` (and `err` if set) high. Then clear `done`, `err` and `gnt`, and return to IDLE.
- `ss_n[i]` = `drv_ss_n` when `i`==`owner` in START/BUSY; otherwise 1. This path is combinational.
- A requester drops `req` in the cycle after `done`. A request still high in IDLE is arbitrated anew, after the other pending requesters because of the pointer.
- `req` falling while in START/BUSY is ignored. The transaction completes and `done` is still pulsed.
- A transaction never returns to IDLE without passing DONE.

## Timing
- Reset values (asynchronous):
  - state IDLE;
  - `last`=N_REQ-1, so requester 0 wins first;
  - `gnt`, `done`, `err`, `start_cmd` = 0;
  - `n_clks`, `tx_data`, `rx_data` = 0;
  - `ss_n` all 1.
- Latency:
  - `req` sampled high in IDLE with `spi_drv_rdy`=1 gives `start_cmd` and `gnt` high at the next edge (1 cycle).
  - `spi_drv_rdy` sampled rising in BUSY gives `done` one cycle later.
- Rejected request: `done`+`err` 1 cycle after arbitration. `start_cmd` never rises.
- `spi_drv_rdy`=0 in IDLE (driver not ready after reset) blocks arbitration. Requests wait; none are dropped.
- Simultaneous requests: exactly one `gnt` bit is ever high. No requester waits more than N_REQ-1 transactions.
- Reset mid-transaction: outputs return to reset values immediately. No completion is reported. The driver shares `reset_n` and is reset in the same event.

## Structure
- Shared package `spi_pkg`:
  - `spi_arb_state_t` enum;
  - `LEN_W` helper function;
  - default `SPI_MAXLEN` localparam, reused by `spi_drv` users.
- Sub-module `rr_arbiter`:
  - combinational winner pick from `req` and `last`;
  - outputs a one-hot grant plus an index;
  - reusable elsewhere.
- The FSM, registers and `ss_n` demux live in `spi_arbiter`. A bench-level top wires `spi_arbiter` to `spi_drv`, with `CLK_DIVIDE`=4 for speed.

## Test plan
- Single request: `req[0]`, `req_n_clks`=8, `req_tx_data`=0xA5, MISO loopback → MOSI bits 1,0,1,0,0,1,0,1; `rx_data`=0xA5; `done[0]` high 1 cycle; only `ss_n[0]` toggles.
- Contention: `req`=4'b1111 held, reissued after each `done` → grant order 0,1,2,3,0; one `gnt` bit at a time.
- Rejection: `req[2]` with `req_n_clks`=0, then =33 → `done[2]`+`err`=1 one cycle after arbitration; `start_cmd` stays 0; `rx_data` unchanged.
- Full width: `req_n_clks`=32, `req_tx_data`=0xDEADBEEF, loopback → `rx_data`=0xDEADBEEF.
- Reset during BUSY of `req[1]` → `gnt`=0, `start_cmd`=0, `ss_n`=all 1 immediately; a new `req[3]` after release is granted first.
